spi_slave_ctrl: RTL and testbench

Byte-oriented SPI slave for the FPGA fabric. Receives MOSI bytes from an external or on-chip SPI master (e.g. the existing `spi_master`) and presents each byte in the system clock domain with a one-cycle valid strobe. Serialises a host-supplied byte onto MISO. All SPI pins are oversampled in the single system clock domain; there is no logic clocked by SCLK.

---
 rtl/spi_slave_ctrl_pkg.sv | 11 +
 rtl/spi_slave_ctrl_if.sv | 9 +
 rtl/spi_slave_ctrl_sync_edge.sv | 36 +++
 rtl/spi_slave_ctrl.sv | 101 ++++++++++
 tb/tb_spi_slave_ctrl.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_slave_ctrl_pkg.sv
// spi_slave_ctrl_pkg: shared constants, frame state and SPI mode decoding
package spi_slave_ctrl_pkg;
  localparam int SYNC_DEPTH = 2;
  typedef enum logic {ST_IDLE, ST_FRAME} frame_st_e;
  function automatic logic mode_cpol(input logic [1:0] mode);
    return mode[1];
  endfunction
  function automatic logic mode_cpha(input logic [1:0] mode);
    return mode[0];
  endfunction
endpackage

// File: rtl/spi_slave_ctrl_if.sv
// spi_slave_ctrl_if: host-side byte handshake between the SPI slave and fabric logic
interface spi_slave_ctrl_if;
  logic       rx_dv;
  logic [7:0] rx_byte;
  logic       tx_dv;
  logic [7:0] tx_byte;
  modport slave (output rx_dv, rx_byte, input tx_dv, tx_byte);
  modport master (input rx_dv, rx_byte, output tx_dv, tx_byte);
endinterface

// File: rtl/spi_slave_ctrl_sync_edge.sv
// spi_sync_edge: 2-FF synchroniser with registered rising/falling edge pulses
module spi_sync_edge
  import spi_slave_ctrl_pkg::*;
#(
  parameter logic INIT = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  logic prev_q, prev_d, rise_q, rise_d, fall_q, fall_d;
  always_comb begin
    sync_d = {sync_q[SYNC_DEPTH-2:0], d};
    prev_d = sync_q[SYNC_DEPTH-1];
    rise_d = sync_q[SYNC_DEPTH-1] & ~prev_q;
    fall_d = ~sync_q[SYNC_DEPTH-1] & prev_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= {SYNC_DEPTH{INIT}};
      prev_q <= INIT;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      rise_q <= rise_d;
      fall_q <= fall_d;
    end
  end
  assign rise = rise_q;
  assign fall = fall_q;
endmodule

// File: rtl/spi_slave_ctrl.sv
// spi_slave_ctrl: oversampled byte-oriented SPI slave, all logic in the system clock domain
module spi_slave_ctrl
  import spi_slave_ctrl_pkg::*;
#(
  parameter int SPI_MODE = 0
) (
  input  logic                   i_Clk,
  input  logic                   i_Rst,
  spi_slave_ctrl_if.slave        bus,
  input  logic                   i_SPI_Clk,
  input  logic                   i_SPI_MOSI,
  input  logic                   i_SPI_CS_n,
  output logic                   o_SPI_MISO
);
  localparam logic CPOL = mode_cpol(2'(SPI_MODE));
  localparam logic CPHA = mode_cpha(2'(SPI_MODE));
  logic sclk_rise, sclk_fall, cs_rise, cs_fall;
  logic leading, trailing, sample, shift, mosi;
  logic [SYNC_DEPTH-1:0] mosi_q;
  logic [7:0] load_val;
  frame_st_e state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [7:0] rx_sr_q, rx_sr_d, rx_byte_q, rx_byte_d, tx_sr_q, tx_sr_d, hold_q, hold_d;
  logic rx_dv_q, rx_dv_d, done_q, done_d, miso_q, miso_d;
  spi_sync_edge #(.INIT(CPOL)) u_sclk (
    .clk(i_Clk), .rst(i_Rst), .d(i_SPI_Clk), .rise(sclk_rise), .fall(sclk_fall)
  );
  // CS_n resets to "low" so a pin held low through reset never looks like a fresh assertion
  spi_sync_edge #(.INIT(1'b0)) u_cs (
    .clk(i_Clk), .rst(i_Rst), .d(i_SPI_CS_n), .rise(cs_rise), .fall(cs_fall)
  );
  assign mosi = mosi_q[SYNC_DEPTH-1];
  always_comb begin
    leading   = CPOL ? sclk_fall : sclk_rise;
    trailing  = CPOL ? sclk_rise : sclk_fall;
    sample    = CPHA ? trailing : leading;
    shift     = CPHA ? leading : trailing;
    load_val  = bus.tx_dv ? bus.tx_byte : hold_q;
    hold_d    = load_val;
    state_d   = state_q;
    cnt_d     = cnt_q;
    rx_sr_d   = rx_sr_q;
    rx_byte_d = rx_byte_q;
    rx_dv_d   = 1'b0;
    done_d    = done_q;
    tx_sr_d   = tx_sr_q;
    miso_d    = miso_q;
    if (state_q == ST_IDLE) begin
      cnt_d   = '0;
      rx_sr_d = '0;
      done_d  = 1'b0;
      tx_sr_d = cs_fall ? (CPHA ? load_val : {load_val[6:0], 1'b0}) : '0;
      miso_d  = cs_fall && !CPHA && load_val[7];
      state_d = cs_fall ? ST_FRAME : ST_IDLE;
    end else if (cs_rise) begin
      state_d = ST_IDLE;
    end else begin
      if (sample) begin
        rx_sr_d   = {rx_sr_q[6:0], mosi};
        cnt_d     = cnt_q + 3'd1;
        rx_dv_d   = cnt_q == 3'd7;
        rx_byte_d = rx_dv_d ? rx_sr_d : rx_byte_q;
        done_d    = rx_dv_d | done_q;
      end
      // the first shift edge after a full byte reloads from the holding register
      if (shift) begin
        miso_d  = done_q ? load_val[7] : tx_sr_q[7];
        tx_sr_d = done_q ? {load_val[6:0], 1'b0} : {tx_sr_q[6:0], 1'b0};
        done_d  = 1'b0;
      end
    end
  end
  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      mosi_q    <= '0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      rx_sr_q   <= '0;
      rx_byte_q <= '0;
      rx_dv_q   <= 1'b0;
      done_q    <= 1'b0;
      tx_sr_q   <= '0;
      hold_q    <= '0;
      miso_q    <= 1'b0;
    end else begin
      mosi_q    <= {mosi_q[SYNC_DEPTH-2:0], i_SPI_MOSI};
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      rx_sr_q   <= rx_sr_d;
      rx_byte_q <= rx_byte_d;
      rx_dv_q   <= rx_dv_d;
      done_q    <= done_d;
      tx_sr_q   <= tx_sr_d;
      hold_q    <= hold_d;
      miso_q    <= miso_d;
    end
  end
  assign bus.rx_dv   = rx_dv_q;
  assign bus.rx_byte = rx_byte_q;
  assign o_SPI_MISO  = (state_q == ST_FRAME) ? miso_q : 1'bz;
endmodule

// File: tb/tb_spi_slave_ctrl.sv
// tb_spi_slave_ctrl: mode 0 and mode 3 slaves driven by a bench SPI master with RX scoreboards
module tb_spi_slave_ctrl;
  localparam int HP = 4;
  logic clk = 0, rst = 1;
  always #5 clk = ~clk;
  logic sclk = 0, mosi = 0, cs0_n = 1, cs3_n = 1;
  wire miso0, miso3;
  logic loop = 0, hdv0 = 0, hdv3 = 0;
  logic [7:0] hb0 = 0, hb3 = 0;
  spi_slave_ctrl_if b0 ();
  spi_slave_ctrl_if b3 ();
  assign b0.tx_dv   = loop ? b0.rx_dv : hdv0;
  assign b0.tx_byte = loop ? b0.rx_byte : hb0;
  assign b3.tx_dv   = hdv3;
  assign b3.tx_byte = hb3;
  spi_slave_ctrl #(.SPI_MODE(0)) dut0 (
    .i_Clk(clk), .i_Rst(rst), .bus(b0), .i_SPI_Clk(sclk), .i_SPI_MOSI(mosi),
    .i_SPI_CS_n(cs0_n), .o_SPI_MISO(miso0)
  );
  spi_slave_ctrl #(.SPI_MODE(3)) dut3 (
    .i_Clk(clk), .i_Rst(rst), .bus(b3), .i_SPI_Clk(sclk), .i_SPI_MOSI(mosi),
    .i_SPI_CS_n(cs3_n), .o_SPI_MISO(miso3)
  );
  int n_chk = 0, n_fail = 0, cnt0 = 0, cnt3 = 0;
  logic [7:0] q0[$], q3[$];
  logic [7:0] e0, e3;
  logic pdv0 = 0, pdv3 = 0;

  always @(negedge clk) begin
    if (b0.rx_dv) begin
      cnt0++;
      n_chk++;
      if (q0.size() == 0) begin
        n_fail++;
        $display("FAIL rx0_unexpected: pulse with byte %h, required no pulse", b0.rx_byte);
      end else begin
        e0 = q0.pop_front();
        if (b0.rx_byte !== e0) begin
          n_fail++;
          $display("FAIL rx0_byte: got %h, required %h", b0.rx_byte, e0);
        end
      end
      n_chk++;
      if (pdv0) begin
        n_fail++;
        $display("FAIL rx0_width: got 2-cycle pulse, required 1");
      end
    end
    if (b3.rx_dv) begin
      cnt3++;
      n_chk++;
      if (q3.size() == 0) begin
        n_fail++;
        $display("FAIL rx3_unexpected: pulse with byte %h, required no pulse", b3.rx_byte);
      end else begin
        e3 = q3.pop_front();
        if (b3.rx_byte !== e3) begin
          n_fail++;
          $display("FAIL rx3_byte: got %h, required %h", b3.rx_byte, e3);
        end
      end
    end
    pdv0 = b0.rx_dv;
    pdv3 = b3.rx_dv;
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic xfer(input bit m3, input logic [15:0] tx, input int nbits,
                      output logic [15:0] rx, output bit stable);
    rx = '0;
    stable = 1;
    sclk = m3;
    cyc(HP);
    if (m3) cs3_n = 0;
    else begin
      cs0_n = 0;
      mosi = tx[15];
    end
    cyc(HP);
    for (int i = 0; i < nbits; i++) begin
      if (m3) begin
        sclk = 0;
        mosi = tx[15-i];
        cyc(HP);
        rx[15-i] = miso3;
        sclk = 1;
        cyc(HP);
        if (miso3 !== rx[15-i]) stable = 0;
      end else begin
        rx[15-i] = miso0;
        sclk = 1;
        cyc(HP);
        sclk = 0;
        if (i + 1 < nbits) mosi = tx[14-i];
        cyc(HP);
      end
    end
    cs0_n = 1;
    cs3_n = 1;
    cyc(2 * HP);
  endtask

  task automatic check_empty(input string name);
    n_chk++;
    if (q0.size() != 0 || q3.size() != 0) begin
      n_fail++;
      $display("FAIL %s: %0d/%0d expected bytes never arrived, required 0/0", name, q0.size(), q3.size());
    end
  endtask

  task automatic test_reset;
    rst = 1;
    cyc(4);
    n_chk++;
    if (b0.rx_dv !== 1'b0 || b3.rx_dv !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_dv: got %b/%b, required 0/0", b0.rx_dv, b3.rx_dv);
    end
    n_chk++;
    if (b0.rx_byte !== 8'h00 || b3.rx_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_byte: got %h/%h, required 00/00", b0.rx_byte, b3.rx_byte);
    end
    rst = 0;
    cyc(4);
  endtask

  task automatic test_two_bytes;
    logic [15:0] rx;
    bit st;
    q0.push_back(8'hAA);
    q0.push_back(8'hBB);
    xfer(0, 16'hAABB, 16, rx, st);
    cyc(8);
    check_empty("two_bytes_pending");
    n_chk++;
    if (rx !== 16'h0000) begin
      n_fail++;
      $display("FAIL two_bytes_miso: got %h, required 0000", rx);
    end
    n_chk++;
    if (b0.rx_byte !== 8'hBB) begin
      n_fail++;
      $display("FAIL two_bytes_hold: got %h, required bb", b0.rx_byte);
    end
  endtask

  task automatic test_preload;
    logic [15:0] rx;
    bit st;
    hb0 = 8'h5A;
    hdv0 = 1;
    cyc(1);
    hdv0 = 0;
    q0.push_back(8'h11);
    xfer(0, 16'h1100, 8, rx, st);
    cyc(8);
    check_empty("preload_pending");
    n_chk++;
    if (rx[15:8] !== 8'h5A) begin
      n_fail++;
      $display("FAIL preload_miso: got %h, required 5a", rx[15:8]);
    end
  endtask

  task automatic test_loopback;
    logic [15:0] rx;
    bit st;
    loop = 1;
    q0.push_back(8'hAA);
    q0.push_back(8'hBB);
    xfer(0, 16'hAABB, 16, rx, st);
    cyc(8);
    loop = 0;
    check_empty("loopback_pending");
    n_chk++;
    if (rx !== 16'h5AAA) begin
      n_fail++;
      $display("FAIL loopback_miso: got %h, required 5aaa", rx);
    end
  endtask

  task automatic test_partial_cs;
    logic [15:0] rx;
    bit st;
    int c;
    c = cnt0;
    xfer(0, 16'hF800, 5, rx, st);
    cyc(8);
    n_chk++;
    if (cnt0 !== c) begin
      n_fail++;
      $display("FAIL partial_no_dv: got %0d pulses, required 0", cnt0 - c);
    end
    q0.push_back(8'h3C);
    xfer(0, 16'h3C00, 8, rx, st);
    cyc(8);
    check_empty("partial_pending");
    n_chk++;
    if (cnt0 !== c + 1) begin
      n_fail++;
      $display("FAIL partial_full_dv: got %0d pulses, required 1", cnt0 - c);
    end
  endtask

  task automatic test_mode3;
    logic [15:0] rx;
    bit st;
    hb3 = 8'h96;
    hdv3 = 1;
    cyc(1);
    hdv3 = 0;
    q3.push_back(8'hC3);
    xfer(1, 16'hC300, 8, rx, st);
    cyc(8);
    check_empty("mode3_pending");
    n_chk++;
    if (rx[15:8] !== 8'h96) begin
      n_fail++;
      $display("FAIL mode3_miso: got %h, required 96", rx[15:8]);
    end
    n_chk++;
    if (st !== 1'b1) begin
      n_fail++;
      $display("FAIL mode3_miso_edge: got change after rising SCLK, required falling only");
    end
    n_chk++;
    if (b3.rx_byte !== 8'hC3) begin
      n_fail++;
      $display("FAIL mode3_byte: got %h, required c3", b3.rx_byte);
    end
    sclk = 0;
    cyc(HP);
  endtask

  task automatic test_reset_mid;
    logic [15:0] rx;
    bit st;
    int c;
    c = cnt0;
    cs0_n = 0;
    cyc(HP);
    for (int i = 0; i < 5; i++) begin
      mosi = 1;
      sclk = 1;
      cyc(HP);
      sclk = 0;
      cyc(HP);
    end
    rst = 1;
    for (int i = 0; i < 3; i++) begin
      sclk = 1;
      cyc(HP);
      sclk = 0;
      cyc(HP);
      n_chk++;
      if (b0.rx_dv !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_mid_dv: got %b during reset, required 0", b0.rx_dv);
      end
    end
    rst = 0;
    cyc(1);
    n_chk++;
    if (b0.rx_byte !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_mid_byte: got %h, required 00", b0.rx_byte);
    end
    for (int i = 0; i < 8; i++) begin
      sclk = 1;
      cyc(HP);
      sclk = 0;
      cyc(HP);
    end
    cyc(8);
    n_chk++;
    if (cnt0 !== c) begin
      n_fail++;
      $display("FAIL reset_mid_resume: got %0d pulses before new CS fall, required 0", cnt0 - c);
    end
    cs0_n = 1;
    cyc(8);
    q0.push_back(8'h81);
    xfer(0, 16'h8100, 8, rx, st);
    cyc(8);
    check_empty("reset_mid_pending");
    n_chk++;
    if (cnt0 !== c + 1) begin
      n_fail++;
      $display("FAIL reset_mid_frame: got %0d pulses, required 1", cnt0 - c);
    end
  endtask

  initial begin
    test_reset();
    test_two_bytes();
    test_preload();
    test_loopback();
    test_partial_cs();
    test_mode3();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
